// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan
// Description : Time-multiplexed driver for a 4-digit common-anode 7-segment
//               display. Scans one digit per divider tick, snapshots the BCD
//               digits once per frame so a frame never mixes two values,
//               blanks leading zeros and drives active-low anode, segment
//               and decimal-point lines from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,     // asynchronous, active-low
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_en,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         DIV     = CLK_HZ / SCAN_HZ;
  localparam int         CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_TERM   = CW'(DIV - 1);
  localparam logic [6:0]    C_SEG_OFF = 7'h7F;
  localparam logic [6:0]    C_SEG_DASH = 7'h3F;
  localparam logic [3:0]    C_AN_OFF  = 4'hF;

  // --------------------------------------------------------------------------
  // BCD to active-low segment pattern {g,f,e,d,c,b,a}; non-BCD shows a dash
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_decode(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = C_SEG_DASH;
    endcase
    return pat;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;

  // Digit 0 is only ever shown on the capture edge itself, taken straight
  // from the live inputs, so only digits 1..3 need a stored copy.
  logic [3:0]    snap_d1_q;
  logic [3:0]    snap_d2_q;
  logic [3:0]    snap_d3_q;
  logic [3:1]    snap_dp_q;
  logic          snap_blank_q;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  // Next-state / combinational
  logic          tick;
  logic          wrap;
  logic [1:0]    idx_d;
  logic [3:0]    cur_dig;
  logic          cur_dp_en;
  logic          cur_blank;
  logic          zero3;
  logic          zero2;
  logic          zero1;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  // Divider terminal count, next scan index and frame-wrap detection
  always_comb begin
    tick  = (cnt_q == C_TERM);
    idx_d = idx_q + 2'd1;
    wrap  = tick && (idx_q == 2'd3);
  end

  // Leading-zero detection on the frame snapshot (non-BCD counts as nonzero)
  always_comb begin
    zero3 = (snap_d3_q == 4'd0);
    zero2 = zero3 && (snap_d2_q == 4'd0);
    zero1 = zero2 && (snap_d1_q == 4'd0);
  end

  // Pick the digit, dp enable and blank flag for the digit about to be lit
  always_comb begin
    cur_dig   = 4'd0;
    cur_dp_en = 1'b0;
    cur_blank = 1'b0;
    case (idx_d)
      2'd0: begin
        cur_dig   = d0;
        cur_dp_en = dp_en[0];
        cur_blank = 1'b0;
      end
      2'd1: begin
        cur_dig   = snap_d1_q;
        cur_dp_en = snap_dp_q[1];
        cur_blank = snap_blank_q && zero1;
      end
      2'd2: begin
        cur_dig   = snap_d2_q;
        cur_dp_en = snap_dp_q[2];
        cur_blank = snap_blank_q && zero2;
      end
      default: begin
        cur_dig   = snap_d3_q;
        cur_dp_en = snap_dp_q[3];
        cur_blank = snap_blank_q && zero3;
      end
    endcase
  end

  // Output values for the next slot; a blanked digit keeps its anode active
  always_comb begin
    an_d  = ~(4'b0001 << idx_d);
    seg_d = cur_blank ? C_SEG_OFF : f_decode(cur_dig);
    dp_d  = ~cur_dp_en;
  end

  // Free-running scan divider producing one tick every DIV cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Scan index advances one digit per tick; reset value 3 makes the first
  // tick wrap to digit 0 and take a fresh snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= 2'd3;
    end else if (tick) begin
      idx_q <= idx_d;
    end
  end

  // Frame snapshot, captured only when the scan wraps back to digit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_d1_q    <= 4'd0;
      snap_d2_q    <= 4'd0;
      snap_d3_q    <= 4'd0;
      snap_dp_q    <= 3'd0;
      snap_blank_q <= 1'b0;
    end else if (wrap) begin
      snap_d1_q    <= d1;
      snap_d2_q    <= d2;
      snap_d3_q    <= d3;
      snap_dp_q    <= dp_en[3:1];
      snap_blank_q <= blank_en;
    end
  end

  // Registered display outputs, dark in reset and updated only on ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= C_AN_OFF;
      seg_q <= C_SEG_OFF;
      dp_q  <= 1'b1;
    end else if (tick) begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan
// Description : Directed self-checking bench for seven_seg_scan with DIV=4.
//               Expected anode/segment/dp values are hand-derived per slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  logic       clk;
  logic       reset;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] dp_en;
  logic       blank_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int         n_vec;
  int         n_miss;

  // Expected value of the slot currently on display
  logic [3:0] prev_an;
  logic [6:0] prev_seg;
  logic       prev_dp;

  seven_seg_scan #(
    .CLK_HZ  (40),
    .SCAN_HZ (10)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .dp_en    (dp_en),
    .blank_en (blank_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {an,seg,dp} against the expected triple
  task automatic check_vec(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               tag, obs[11:8], obs[7:1], obs[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
    end
  endtask

  task automatic set_dark();
    prev_an  = 4'hF;
    prev_seg = 7'h7F;
    prev_dp  = 1'b1;
  endtask

  // Three edges holding the previous slot, then the tick edge showing the new one
  task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    repeat (3) @(posedge clk);
    #1;
    check_vec({tag, "_hold"}, {an, seg, dp}, {prev_an, prev_seg, prev_dp});
    @(posedge clk);
    #1;
    check_vec(tag, {an, seg, dp}, {ea, es, ed});
    prev_an  = ea;
    prev_seg = es;
    prev_dp  = ed;
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    reset    = 1'b0;
    d0       = 4'd0;
    d1       = 4'd0;
    d2       = 4'd0;
    d3       = 4'd0;
    dp_en    = 4'd0;
    blank_en = 1'b0;
    set_dark();

    // Reset held: inputs toggle, outputs stay dark
    for (int i = 0; i < 4; i++) begin
      d0       = 4'(i + 1);
      d1       = 4'(i + 5);
      dp_en    = 4'(i * 5);
      blank_en = i[0];
      @(negedge clk);
      check_vec("rst_hold", {an, seg, dp}, 12'hFFF);
    end

    // Count 1,2,3,4 without blanking; release on a falling edge
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    dp_en = 4'b0000; blank_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    slot("first_d0", 4'hE, 7'h19, 1'b1);
    slot("cnt_d1",   4'hD, 7'h30, 1'b1);
    slot("cnt_d2",   4'hB, 7'h24, 1'b1);
    slot("cnt_d3",   4'h7, 7'h79, 1'b1);
    slot("cnt2_d0",  4'hE, 7'h19, 1'b1);
    slot("cnt2_d1",  4'hD, 7'h30, 1'b1);
    slot("cnt2_d2",  4'hB, 7'h24, 1'b1);
    slot("cnt2_d3",  4'h7, 7'h79, 1'b1);

    // Leading-zero blanking: 0007, then 0000
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd7; blank_en = 1'b1;
    slot("blk7_d0", 4'hE, 7'h78, 1'b1);
    slot("blk7_d1", 4'hD, 7'h7F, 1'b1);
    slot("blk7_d2", 4'hB, 7'h7F, 1'b1);
    slot("blk7_d3", 4'h7, 7'h7F, 1'b1);
    d0 = 4'd0;
    slot("blk0_d0", 4'hE, 7'h40, 1'b1);
    slot("blk0_d1", 4'hD, 7'h7F, 1'b1);
    slot("blk0_d2", 4'hB, 7'h7F, 1'b1);
    slot("blk0_d3", 4'h7, 7'h7F, 1'b1);

    // Tear-free snapshot: change mid-frame, visible only next frame
    blank_en = 1'b0; d0 = 4'd5;
    slot("snap_d0", 4'hE, 7'h12, 1'b1);
    d1 = 4'd8; d0 = 4'd9;
    slot("snap_d1", 4'hD, 7'h40, 1'b1);
    slot("snap_d2", 4'hB, 7'h40, 1'b1);
    slot("snap_d3", 4'h7, 7'h40, 1'b1);
    slot("snap2_d0", 4'hE, 7'h10, 1'b1);
    slot("snap2_d1", 4'hD, 7'h00, 1'b1);
    slot("snap2_d2", 4'hB, 7'h40, 1'b1);
    slot("snap2_d3", 4'h7, 7'h40, 1'b1);

    // Non-BCD dash counts as nonzero; dp driven on a blanked digit
    d3 = 4'd0; d2 = 4'd0; d1 = 4'hC; d0 = 4'd1;
    dp_en = 4'b0100; blank_en = 1'b1;
    slot("nbcd_d0", 4'hE, 7'h79, 1'b1);
    slot("nbcd_d1", 4'hD, 7'h3F, 1'b1);
    slot("nbcd_d2", 4'hB, 7'h7F, 1'b0);
    slot("nbcd_d3", 4'h7, 7'h7F, 1'b1);
    slot("nbcd2_d0", 4'hE, 7'h79, 1'b1);
    slot("nbcd2_d1", 4'hD, 7'h3F, 1'b1);
    slot("nbcd2_d2", 4'hB, 7'h7F, 1'b0);

    // Mid-frame reset while digit 2 is lit
    reset = 1'b0;
    #1;
    check_vec("rst_async", {an, seg, dp}, 12'hFFF);
    @(negedge clk);
    check_vec("rst_mid", {an, seg, dp}, 12'hFFF);
    @(negedge clk);
    reset = 1'b1;
    set_dark();
    slot("rst_d0", 4'hE, 7'h79, 1'b1);
    slot("rst_d1", 4'hD, 7'h3F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
